// File: rtl/sha512_msg_schedule.sv
// ---------------------------------------------------------------------------
// sha512_msg_schedule
//
// Streams the SHA-512 message schedule W[0..NUM_ROUNDS-1] for one 1024-bit
// block. The sixteen 64-bit message words are loaded serially in order
// (M[0] first). The block then emits one W word per out handshake. Rounds
// 0..15 echo the loaded words. Later rounds are expanded in place in a
// 16-deep sliding window.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset; clears all state
//   abort      synchronous drop of the current block, back to LOAD
//   in_valid   in_word carries a message word
//   in_ready   block accepts a message word this cycle (LOAD phase)
//   in_word    64-bit big-endian message word
//   out_valid  out_w/out_round carry a schedule word (STREAM phase)
//   out_ready  consumer takes the word this cycle
//   out_w      schedule word W[t]
//   out_round  round index t
//   out_last   out_valid and out_round == NUM_ROUNDS-1
// ---------------------------------------------------------------------------
module sha512_msg_schedule #(
  parameter int NUM_ROUNDS = 80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        abort,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_w,
  output logic [6:0]  out_round,
  output logic        out_last
);

  localparam logic [6:0] LAST_RND = 7'(NUM_ROUNDS - 1);

  typedef enum logic {S_LOAD, S_STREAM} state_t;

  state_t            r_state;
  logic [15:0][63:0] r_win;       // r_win[0] is the oldest word (W[t])
  logic [4:0]        r_ld_cnt;
  logic [6:0]        r_round;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_out_last;

  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_shift;
  logic [63:0]       w_push;
  logic [63:0]       w_next;

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] sig0(input logic [63:0] x);
    return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] sig1(input logic [63:0] x);
    return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
  endfunction

  // W[t+16] from the current window, where r_win[k] holds W[t+k].
  assign w_next = sig1(r_win[14]) + r_win[9] + sig0(r_win[1]) + r_win[0];

  // The handshakes qualify on the registered ready/valid flags. out_ready
  // in LOAD and in_valid in STREAM therefore have no effect.
  assign w_in_fire  = in_valid  & r_in_ready;
  assign w_out_fire = out_ready & r_out_valid;

  always_comb begin
    w_shift = 1'b0;
    w_push  = in_word;
    if (!abort) begin
      if (r_state == S_LOAD && w_in_fire) begin
        w_shift = 1'b1;
        w_push  = in_word;
      end else if (r_state == S_STREAM && w_out_fire) begin
        w_shift = 1'b1;
        w_push  = w_next;
      end
    end
  end

  // The window holds its contents across an abort. The next block
  // overwrites all 16 entries before it is read, so stale words never leak.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_win <= '0;
    end else if (w_shift) begin
      r_win <= {w_push, r_win[15:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_LOAD;
      r_ld_cnt    <= '0;
      r_round     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (abort) begin
      r_state     <= S_LOAD;
      r_ld_cnt    <= '0;
      r_round     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_in_fire) begin
            r_ld_cnt <= r_ld_cnt + 5'd1;
            if (r_ld_cnt == 5'd15) begin
              r_state     <= S_STREAM;
              r_round     <= '0;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_last  <= (LAST_RND == 7'd0);
            end
          end
        end
        S_STREAM: begin
          if (w_out_fire) begin
            if (r_round == LAST_RND) begin
              r_state     <= S_LOAD;
              r_ld_cnt    <= '0;
              r_round     <= '0;
              r_in_ready  <= 1'b1;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
            end else begin
              r_round    <= r_round + 7'd1;
              r_out_last <= ((r_round + 7'd1) == LAST_RND);
            end
          end
        end
        default: begin
          r_state     <= S_LOAD;
          r_ld_cnt    <= '0;
          r_round     <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_w     = r_win[0];
  assign out_round = r_round;
  assign out_last  = r_out_last;

endmodule
